// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I) and
// the load/store stage (D). Only one transaction is in flight at a time.
// D has priority. After STARVE_LIMIT consecutive lost contests, I is forced to win.
// Ports:
//   clk, rst                        clock, async active-high reset
//   if_req/if_addr                  fetch request, held until if_ack
//   if_ack/if_err/if_rdata          fetch completion pulse, error flag, instruction
//   d_req/d_we/d_addr/d_width/d_wdata  data request and payload, held until d_ack
//   d_ack/d_err/d_rdata             data completion pulse, error flag, load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_width  registered memory transaction
//   mem_ack/mem_rdata               memory completion and read data
//   busy                            arbiter not idle
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_err,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [2:0]        d_width,
    input  logic [63:0]       d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [63:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [2:0]        mem_width,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;

    logic        grant_d;
    logic        grant_i;
    logic        contested;
    logic        if_bad;
    logic        d_bad;
    logic [63:0] load_data;

    // Arbitration: D wins unless fetch has lost LIMIT contests in a row.
    assign contested = if_req && d_req;
    assign grant_d   = d_req && !(if_req && (starve_cnt == LIMIT));
    assign grant_i   = if_req && !grant_d;

    // Misaligned fetch (instructions are 32-bit).
    assign if_bad = (if_addr[1:0] != 2'b00);

    // The data address must be aligned to the access size. Width codes above 3 are illegal.
    always_comb begin
        d_bad = 1'b1;
        case (d_width)
            3'd0:    d_bad = 1'b0;
            3'd1:    d_bad = d_addr[0];
            3'd2:    d_bad = (d_addr[1:0] != 2'b00);
            3'd3:    d_bad = (d_addr[2:0] != 3'b000);
            default: d_bad = 1'b1;
        endcase
    end

    // Load data zero-extended from the latched access width.
    always_comb begin
        load_data = mem_rdata;
        case (mem_width[1:0])
            2'd0:    load_data = {56'd0, mem_rdata[7:0]};
            2'd1:    load_data = {48'd0, mem_rdata[15:0]};
            2'd2:    load_data = {32'd0, mem_rdata[31:0]};
            default: load_data = mem_rdata;
        endcase
    end

    // Arbiter FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            if_ack     <= 1'b0;
            if_err     <= 1'b0;
            if_rdata   <= '0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_width  <= '0;
            busy       <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            if_err <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        if (contested && (starve_cnt < LIMIT)) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                        busy <= 1'b1;
                        if (d_bad) begin
                            d_ack   <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                            state   <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_width <= d_width;
                            state     <= BUSY_D;
                        end
                    end else if (grant_i) begin
                        starve_cnt <= '0;
                        busy       <= 1'b1;
                        if (if_bad) begin
                            if_ack   <= 1'b1;
                            if_err   <= 1'b1;
                            if_rdata <= '0;
                            state    <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_width <= 3'd2;
                            state     <= BUSY_I;
                        end
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata[31:0];
                        if_ack   <= 1'b1;
                        state    <= RESP;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        d_rdata <= mem_we ? 64'd0 : load_data;
                        d_ack   <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, randomized
// transactions against a behavioural model, and multi-cycle corner sequences.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned LIMIT  = 4;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic              if_err;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [2:0]        d_width;
    logic [63:0]       d_wdata;
    logic              d_ack;
    logic              d_err;
    logic [63:0]       d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [2:0]        mem_width;
    logic              mem_ack;
    logic [63:0]       mem_rdata;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_width(d_width), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_width(mem_width), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          fetch;
        bit          we;
        logic [63:0] addr;
        logic [2:0]  width;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          waits;
        bit          exp_err;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: result of one access, derived from size/alignment arithmetic.
    function automatic void model(input bit fetch, input bit we, input logic [63:0] addr,
                                  input logic [2:0] width, input logic [63:0] rdata,
                                  output bit err, output logic [63:0] rd);
        longint unsigned bytes;
        if (fetch) begin
            err = (addr % 64'd4) != 64'd0;
            rd  = err ? 64'd0 : rdata % (64'd1 << 32);
        end else if (width > 3'd3) begin
            err = 1'b1;
            rd  = 64'd0;
        end else begin
            bytes = 64'd1 << width;
            err   = (addr % bytes) != 64'd0;
            if (err || we)      rd = 64'd0;
            else if (bytes == 8) rd = rdata;
            else                 rd = rdata % (64'd1 << (8 * bytes));
        end
    endfunction

    // Drive one request, act as memory with 'waits' wait cycles, check the response.
    task automatic run_txn(input bit fetch, input bit we, input logic [63:0] addr,
                           input logic [2:0] width, input logic [63:0] wdata,
                           input logic [63:0] rdata, input int waits,
                           input bit e_err, input logic [63:0] e_rd, input string tag);
        int lat = 0;
        int mcyc = 0;
        bit done = 1'b0;
        bit other = 1'b0;
        bit pay_bad = 1'b0;
        logic        a_err;
        logic [63:0] a_rd;
        if (fetch) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_width = width; d_wdata = wdata;
        end
        while (!done && lat < 40) begin
            mem_ack   = 1'b0;
            mem_rdata = {$urandom, $urandom};
            if (mem_req) begin
                if (mem_we !== (fetch ? 1'b0 : we) || mem_addr !== addr ||
                    mem_width !== (fetch ? 3'd2 : width) ||
                    mem_wdata !== (fetch ? 64'd0 : wdata)) pay_bad = 1'b1;
                if (mcyc == waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                mcyc++;
            end
            tick();
            lat++;
            if (fetch ? d_ack : if_ack) other = 1'b1;
            if (fetch ? if_ack : d_ack) done = 1'b1;
        end
        mem_ack = 1'b0;
        if_req  = 1'b0;
        d_req   = 1'b0;
        a_err   = fetch ? if_err : d_err;
        a_rd    = fetch ? 64'(if_rdata) : d_rdata;
        chk({tag, " ack"}, 64'(done), 64'd1);
        chk({tag, " err"}, 64'(a_err), 64'(e_err));
        chk({tag, " rdata"}, a_rd, e_rd);
        chk({tag, " latency"}, 64'(lat), e_err ? 64'd1 : 64'(waits + 2));
        chk({tag, " mem_req cycles"}, 64'(mcyc), e_err ? 64'd0 : 64'(waits + 1));
        chk({tag, " payload"}, 64'(pay_bad), 64'd0);
        chk({tag, " foreign ack"}, 64'(other), 64'd0);
        tick();
        chk({tag, " idle after"}, 64'({busy, if_ack, d_ack}), 64'd0);
    endtask

    initial begin
        bit          f, w, e_err;
        logic [63:0] a, rd, e_rd;
        logic [2:0]  wd;
        int          n, cyc, i_cnt, d_cnt;
        bit          stable, order_i[10], both;

        vecs[0]  = '{1, 0, 64'h1000, 3'd0, 64'h0, 64'hAABBCCDD_00000013, 0, 0, 64'h13};
        vecs[1]  = '{0, 0, 64'h2002, 3'd1, 64'h0, 64'hFFFF_FFFF_FFFF_8765, 0, 0, 64'h8765};
        vecs[2]  = '{0, 1, 64'h2004, 3'd3, 64'h55, 64'h0, 0, 1, 64'h0};
        vecs[3]  = '{0, 0, 64'h2000, 3'd5, 64'h0, 64'h1234, 0, 1, 64'h0};
        vecs[4]  = '{1, 0, 64'h1002, 3'd0, 64'h0, 64'h1234, 0, 1, 64'h0};
        vecs[5]  = '{0, 0, 64'h2003, 3'd0, 64'h0, 64'h1122334455667788, 1, 0, 64'h88};
        vecs[6]  = '{0, 0, 64'h2004, 3'd2, 64'h0, 64'h1122334455667788, 0, 0, 64'h55667788};
        vecs[7]  = '{0, 0, 64'h2008, 3'd3, 64'h0, 64'h1122334455667788, 2, 0, 64'h1122334455667788};
        vecs[8]  = '{0, 1, 64'h200C, 3'd2, 64'hDEADBEEF, 64'hFFFF, 0, 0, 64'h0};
        vecs[9]  = '{0, 0, 64'h2001, 3'd1, 64'h0, 64'hFFFF, 0, 1, 64'h0};
        vecs[10] = '{0, 0, 64'h2006, 3'd2, 64'h0, 64'hFFFF, 0, 1, 64'h0};
        vecs[11] = '{0, 0, 64'h2000, 3'd7, 64'h0, 64'hFFFF, 0, 1, 64'h0};

        rst = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
        d_width = '0; d_wdata = '0; mem_ack = 0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", 64'({if_ack, if_err, if_rdata, d_ack, d_err, mem_req, mem_we,
                                  mem_width, busy}) | d_rdata | mem_addr | mem_wdata, 64'd0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Directed vector table
        foreach (vecs[k])
            run_txn(vecs[k].fetch, vecs[k].we, vecs[k].addr, vecs[k].width, vecs[k].wdata,
                    vecs[k].rdata, vecs[k].waits, vecs[k].exp_err, vecs[k].exp_rd,
                    $sformatf("vec%0d", k));

        // Randomized single transactions against the model
        for (int k = 0; k < 40; k++) begin
            f  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'd0;
            wd = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            rd = {$urandom, $urandom};
            model(f, w, a, wd, rd, e_err, e_rd);
            run_txn(f, w, a, wd, {$urandom, $urandom}, rd, int'($urandom_range(0, 3)),
                    e_err, e_rd, $sformatf("rnd%0d", k));
        end

        // Stray mem_ack while idle must be ignored
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        chk("stray mem_ack", 64'({busy, mem_req, if_ack, d_ack}), 64'd0);

        // Five wait cycles, with a fetch arriving while busy
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h5000; d_width = 3'd3; d_wdata = 64'h0;
        tick();
        stable = 1'b1;
        i_cnt = 0;
        d_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (mem_req !== 1'b1 || mem_addr !== 64'h5000 || mem_width !== 3'd3 || mem_we !== 1'b0)
                stable = 1'b0;
            if (k == 1) begin if_req = 1'b1; if_addr = 64'h6000; end
            mem_ack   = (k == 5);
            mem_rdata = 64'hCAFE_F00D_0000_1111;
            tick();
            i_cnt += int'(if_ack);
            d_cnt += int'(d_ack);
        end
        mem_ack = 1'b0;
        d_req   = 1'b0;
        chk("wait5 payload stable", 64'(stable), 64'd1);
        chk("wait5 d_ack", 64'(d_ack), 64'd1);
        chk("wait5 d_rdata", d_rdata, 64'hCAFE_F00D_0000_1111);
        tick();
        chk("wait5 single ack", 64'({busy, mem_req, if_ack, d_ack}), 64'd0);
        tick();
        chk("late fetch granted", 64'({mem_req, mem_addr[15:0]}), 64'h1_6000);
        mem_ack   = 1'b1;
        mem_rdata = 64'h0000_0000_0000_0067;
        tick();
        mem_ack = 1'b0;
        if_req  = 1'b0;
        i_cnt += int'(if_ack);
        chk("late fetch rdata", 64'(if_rdata), 64'h67);
        tick();
        chk("ack counts", 64'({i_cnt[7:0], d_cnt[7:0]}), 64'h0101);

        // Reset during BUSY_D
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h7000; d_width = 3'd3;
        tick();
        tick();
        chk("busy_d before reset", 64'({mem_req, busy}), 64'h3);
        #1 rst = 1'b1;
        #1;
        chk("async reset outputs", 64'({if_ack, if_err, if_rdata, d_ack, d_err, mem_req, mem_we,
                                        mem_width, busy}) | d_rdata | mem_addr | mem_wdata, 64'd0);
        d_req = 1'b0;
        @(negedge clk) rst = 1'b0;
        tick();
        run_txn(1, 0, 64'h1000, 3'd0, 64'h0, 64'h0000_0000_0000_0093, 0, 0, 64'h93, "post reset");

        // Both requesters held continuously: fetch wins after LIMIT losses
        if_req = 1'b1; if_addr = 64'h3000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h4000; d_width = 3'd3;
        n = 0;
        cyc = 0;
        both = 1'b0;
        while (n < 10 && cyc < 200) begin
            mem_ack   = mem_req;
            mem_rdata = 64'h0;
            tick();
            cyc++;
            if (if_ack && d_ack) both = 1'b1;
            if (if_ack) begin order_i[n] = 1'b1; n++; end
            else if (d_ack) begin order_i[n] = 1'b0; n++; end
        end
        if_req = 1'b0;
        d_req = 1'b0;
        mem_ack = 1'b0;
        chk("starve grant count", 64'(n), 64'd10);
        chk("starve double ack", 64'(both), 64'd0);
        for (int k = 0; k < n; k++)
            chk($sformatf("starve grant%0d is fetch", k), 64'(order_i[k]),
                64'((k % (LIMIT + 1)) == LIMIT));
        tick();
        tick();
        chk("final idle", 64'({busy, mem_req}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between instruction fetch and the load/store stage of the RV64 core. Arbitrates the two requesters, issues one transaction at a time to memory with a req/ack handshake, and returns read data and per-requester acknowledge. Checks alignment against the access width produced by `control_unit` (`data_width` 0=8b, 1=16b, 2=32b, 3=64b). Data access has priority, with a starvation bound for fetch.

## Interface
- `ADDR_W`, 64: address width.
- `STARVE_LIMIT`, 4: consecutive fetch losses before fetch is forced to win; legal range 1..15.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request; held with `if_addr` until `if_ack`.
- `if_addr` in ADDR_W: fetch address.
- `if_ack` out 1: one-cycle completion pulse.
- `if_err` out 1: valid with `if_ack`; misaligned fetch.
- `if_rdata` out 32: instruction, valid with `if_ack`.
- `d_req` in 1: data request; held with payload until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_width` in 3: access width code 0..3; 4..7 illegal.
- `d_wdata` in 64: store data, low-aligned.
- `d_ack` out 1: one-cycle completion pulse.
- `d_err` out 1: valid with `d_ack`; misaligned or illegal width.
- `d_rdata` out 64: load data, zero-extended to width, valid with `d_ack`.
- `mem_req` out 1: transaction valid; held until `mem_ack`.
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_width` out 1/ADDR_W/64/3: registered transaction payload.
- `mem_ack` in 1: memory completion; may assert in the first `mem_req` cycle.
- `mem_rdata` in 64: valid with `mem_ack`.
- `busy` out 1: state != IDLE.

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: requests sampled only here. Winner: `d_req` alone → D; `if_req` alone → I; both → D, unless `starve_cnt == STARVE_LIMIT`, then I.
- `starve_cnt` (4b): +1 at each IDLE edge where both request and D wins; cleared when I wins. Saturates at STARVE_LIMIT.
- Error check at grant. I: `if_addr[1:0] != 0`. D: `d_width > 3`, or addr not aligned to 2^d_width bytes. On error: no memory transaction; go to RESP with the err flag set, rdata = 0.
- Legal grant: latch payload into `mem_*`, set `mem_req` = 1, go to BUSY_I/BUSY_D. Fetch payload: `mem_we` = 0, `mem_width` = 2, `mem_wdata` = 0.
- BUSY_x: hold `mem_req` and payload. On `mem_ack`: clear `mem_req`, capture read data, go to RESP. Fetch captures `mem_rdata[31:0]`. Load captures `mem_rdata` masked to 8/16/32/64 bits. Store captures 0.
- RESP: the owner's ack is high for exactly this cycle, then IDLE. The requester must drop or replace its request by the edge that ends RESP, so a request is never served twice.
- `mem_ack` outside BUSY_x is ignored.

## Timing
- Reset values: state IDLE; `starve_cnt` 0. All acks, errs, `mem_req`, `mem_we` and `busy` are 0. All data, address and width outputs are 0.
- Request seen at IDLE edge k: `mem_req` high in cycle k+1.
- `mem_ack` sampled at edge m: ack/rdata in cycle m+1; IDLE in m+2; next grant sampled at edge m+2.
- Minimum request→ack latency is 2 cycles for a legal access (zero-wait memory), and 1 cycle for an error.
- Back-to-back throughput: one transaction per 3 cycles with zero-wait memory.
- Acks, err and rdata are registered. No combinational path from any input to any output.
- `rst` mid-transaction: immediate return to reset values; the outstanding memory access is abandoned, and memory must tolerate `mem_req` dropping.

## Test plan
- Reset during BUSY_D with `mem_req` = 1 → all outputs 0 asynchronously; after release, a new `if_req` is served normally.
- Only `if_req`, addr 0x1000, `mem_ack` in the first request cycle with rdata 0xAABBCCDD_00000013 → `mem_width` = 2, `mem_we` = 0; `if_ack` 2 cycles after the request with `if_rdata` = 0x00000013 and `if_err` = 0.
- Load with width 1, addr 0x2002, rdata 0xFFFF_FFFF_FFFF_8765 → `d_rdata` = 0x8765. Store with width 3, addr 0x2004 → `d_ack` with `d_err` = 1, and `mem_req` never asserted.
- `if_req` and `d_req` both held continuously, STARVE_LIMIT = 4, requesters re-request immediately after ack → grants in order D,D,D,D,I,D,D,D,D,I.
- Memory with 5 wait cycles: `mem_req` and payload stable for 6 cycles; new requests arriving meanwhile are not granted until IDLE; exactly one ack per transaction.
- `d_width` = 5 → `d_err` = 1 and no memory access. A stray `mem_ack` in IDLE → no ack and no state change.
